// File: rtl/mem_arbiter_pkg.sv
// Shared widths, FSM state encoding and owner encoding for the memory arbiter.
package mem_arbiter_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int FETCH_SIZE = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arbState;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational grant decision between the I and D requesters.
// ARB_RR_EN selects round-robin; otherwise D has fixed priority over I.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic rr_last,
    output logic grant_d
);

`ifdef ARB_RR_EN
    // On a tie the side opposite the last owner wins; a lone requester always wins.
    assign grant_d = d_req && (!i_req || (rr_last == OWN_I));
`else
    logic unusedPickInputs;
    assign unusedPickInputs = i_req ^ rr_last;
    assign grant_d = d_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the I-cache and D-cache, one line access at a time.
// Build option: define ARB_RR_EN for round-robin arbitration instead of D-over-I priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_req,
    input  logic                  i_write,
    input  logic [WORD_SIZE-1:0]  i_addr,
    input  logic [FETCH_SIZE-1:0] i_wdata,
    output logic                  i_ready,
    output logic [FETCH_SIZE-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_write,
    input  logic [WORD_SIZE-1:0]  d_addr,
    input  logic [FETCH_SIZE-1:0] d_wdata,
    output logic                  d_ready,
    output logic [FETCH_SIZE-1:0] d_rdata,
    output logic                  readM,
    output logic                  writeM,
    output logic [WORD_SIZE-1:0]  address,
    output logic [FETCH_SIZE-1:0] mem_wdata,
    input  logic [FETCH_SIZE-1:0] mem_rdata,
    output logic                  busy,
    output logic                  grant_d,
    output logic [1:0]            dbgState
);

    // Handshake: req is a level held until its ready; ready is a one-cycle
    // completion strobe and rdata is valid with it. Inputs are sampled only in IDLE.

    localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

    arbState               state, nextState;
    logic [3:0]            cnt;
    logic                  owner, opWrite;
    logic [WORD_SIZE-1:0]  addrReg;
    logic [FETCH_SIZE-1:0] wdataReg, iRdataReg, dRdataReg;
    logic                  pickD, rrLast, anyReq, lastBeat;

    assign anyReq   = i_req || d_req;
    assign lastBeat = (cnt == LAST_CNT);

    arb_pick uPick (
        .i_req   (i_req),
        .d_req   (d_req),
        .rr_last (rrLast),
        .grant_d (pickD)
    );

`ifdef ARB_RR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rrLast <= OWN_I;
        else if (state == ST_IDLE && anyReq)
            rrLast <= pickD;
    end
`else
    assign rrLast = OWN_I;
`endif

    always_comb begin
        nextState = state;
        readM     = 1'b0;
        writeM    = 1'b0;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (anyReq) nextState = ST_ACCESS;
            end
            ST_ACCESS: begin
                busy   = 1'b1;
                readM  = !opWrite;
                writeM = opWrite;
                if (lastBeat) nextState = ST_RESP;
            end
            ST_RESP: begin
                busy      = 1'b1;
                i_ready   = (owner == OWN_I);
                d_ready   = (owner == OWN_D);
                nextState = ST_IDLE;
            end
            default: nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            owner     <= OWN_I;
            opWrite   <= 1'b0;
            addrReg   <= '0;
            wdataReg  <= '0;
            iRdataReg <= '0;
            dRdataReg <= '0;
        end else begin
            state <= nextState;
            case (state)
                ST_IDLE: begin
                    if (anyReq) begin
                        owner    <= pickD;
                        opWrite  <= pickD ? d_write : i_write;
                        addrReg  <= pickD ? d_addr  : i_addr;
                        wdataReg <= pickD ? d_wdata : i_wdata;
                        cnt      <= '0;
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt + 4'd1;
                    // Read data is taken on the edge that ends the last strobe cycle.
                    if (lastBeat && !opWrite) begin
                        if (owner == OWN_D)
                            dRdataReg <= mem_rdata;
                        else
                            iRdataReg <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign address   = addrReg;
    assign mem_wdata = wdataReg;
    assign i_rdata   = iRdataReg;
    assign d_rdata   = dRdataReg;
    assign grant_d   = owner;
    assign dbgState  = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter; honours ARB_RR_EN in its arbitration model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int L = 4;

    logic                  clk, reset_n;
    logic                  i_req, i_write, d_req, d_write;
    logic [WORD_SIZE-1:0]  i_addr, d_addr, address;
    logic [FETCH_SIZE-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic                  i_ready, d_ready, readM, writeM, busy, grant_d;
    logic [1:0]            dbgState;

    typedef struct packed {
        logic        side;
        logic        write;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [31:0] readyCyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cycleCnt = 0;
    int          strobeCnt = 0;
    int          memCnt = 0;
    bit          accActive = 0;
    logic        modelRr;
    logic [63:0] lastI, lastD;

    mem_arbiter #(.LATENCY(L)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .readM(readM), .writeM(writeM), .address(address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .grant_d(grant_d), .dbgState(dbgState)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cycleCnt);
        end
    endtask

    function automatic logic [63:0] memFn(input logic [15:0] a);
        if (a == 16'h0010) return 64'h0004_0003_0002_0001;
        return {a ^ 16'hA5A5, a, ~a, a + 16'h0101};
    endfunction

    // Memory: the line is valid only during the final read cycle, junk otherwise.
    always @(negedge clk) begin
        if (readM) begin
            memCnt++;
            mem_rdata = (memCnt == L) ? memFn(address) : {$urandom, $urandom};
        end else begin
            memCnt    = 0;
            mem_rdata = {$urandom, $urandom};
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        exp_t cur;
        if (reset_n) begin
            check("one_strobe", readM & writeM, 0);
            if (readM || writeM) begin
                if (!accActive) begin
                    accActive = 1;
                    strobeCnt = 0;
                end
                strobeCnt++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_access actual=addr %h required=no access", address);
                end else begin
                    cur = exp_q[0];
                    check("strobe_op", writeM, cur.write);
                    check("address", address, cur.addr);
                    if (cur.write) check("mem_wdata", mem_wdata, cur.wdata);
                    check("grant_owner", grant_d, cur.side);
                    check("busy_access", busy, 1);
                    check("ready_in_access", i_ready | d_ready, 0);
                end
            end else if (i_ready || d_ready) begin
                check("ready_exclusive", i_ready & d_ready, 0);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_ready actual=i%0b d%0b required=none", i_ready, d_ready);
                end else begin
                    cur = exp_q.pop_front();
                    check("ready_side", d_ready, cur.side);
                    check("strobe_len", strobeCnt, L);
                    check("ready_cycle", cycleCnt, cur.readyCyc);
                    check("busy_resp", busy, 1);
                    if (!cur.write) begin
                        if (cur.side) lastD = memFn(cur.addr);
                        else          lastI = memFn(cur.addr);
                    end
                    check("i_rdata", i_rdata, lastI);
                    check("d_rdata", d_rdata, lastD);
                end
                accActive = 0;
                strobeCnt = 0;
            end else if (!accActive) begin
                check("busy_idle", busy, 0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_round(input bit useI, input bit useD, input logic iw, input logic dw,
                             input logic [15:0] ia, input logic [15:0] da,
                             input logic [63:0] iwd, input logic [63:0] dwd);
        exp_t eI, eD;
        int   n;
        logic first;
        bit   iDone, dDone;
        @(negedge clk); #1;
        n  = cycleCnt;
        eI = '{side: OWN_I, write: iw, addr: ia, wdata: iwd, readyCyc: 32'(n + L + 1)};
        eD = '{side: OWN_D, write: dw, addr: da, wdata: dwd, readyCyc: 32'(n + L + 1)};
        if (useI && useD) begin
`ifdef ARB_RR_EN
            first = ~modelRr;
`else
            first = OWN_D;
`endif
            if (first == OWN_D) begin
                eI.readyCyc = 32'(n + 2 * L + 3);
                exp_q.push_back(eD); exp_q.push_back(eI);
                modelRr = OWN_I;
            end else begin
                eD.readyCyc = 32'(n + 2 * L + 3);
                exp_q.push_back(eI); exp_q.push_back(eD);
                modelRr = OWN_D;
            end
        end else if (useD) begin
            exp_q.push_back(eD);
            modelRr = OWN_D;
        end else begin
            exp_q.push_back(eI);
            modelRr = OWN_I;
        end
        if (useI) begin i_req = 1; i_write = iw; i_addr = ia; i_wdata = iwd; end
        if (useD) begin d_req = 1; d_write = dw; d_addr = da; d_wdata = dwd; end
        iDone = !useI;
        dDone = !useD;
        for (int c = 0; c < 3 * L + 20 && !(iDone && dDone); c++) begin
            @(negedge clk); #1;
            if (i_ready && !iDone) begin i_req = 0; iDone = 1; end
            if (d_ready && !dDone) begin d_req = 0; dDone = 1; end
            // The owner's inputs are scrambled mid-access; they must be ignored.
            if (accActive && exp_q.size() > 0) begin
                if (exp_q[0].side == OWN_D && !dDone) begin
                    d_addr = 16'($urandom); d_wdata = {$urandom, $urandom}; d_write = 1'($urandom);
                end else if (exp_q[0].side == OWN_I && !iDone) begin
                    i_addr = 16'($urandom); i_wdata = {$urandom, $urandom}; i_write = 1'($urandom);
                end
            end
        end
        if (!(iDone && dDone)) begin
            checks++; errors++;
            $display("FAIL round_timeout actual=pending i%0b d%0b required=both done", !iDone, !dDone);
            i_req = 0; d_req = 0;
            exp_q.delete();
            accActive = 0;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int sides;
        reset_n = 0; i_req = 0; i_write = 0; i_addr = 0; i_wdata = 0;
        d_req = 0; d_write = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
        modelRr = OWN_I; lastI = 0; lastD = 0;
        repeat (2) @(negedge clk);
        check("rst_readM", readM, 0);
        check("rst_writeM", writeM, 0);
        check("rst_address", address, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_d", grant_d, 0);
        check("rst_i_ready", i_ready, 0);
        check("rst_d_ready", d_ready, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_state", dbgState, 0);
        #1 reset_n = 1;

        run_round(1, 0, 0, 0, 16'h0010, 16'h0000, 64'h0, 64'h0);
        run_round(0, 1, 0, 1, 16'h0000, 16'h00A0, 64'h0, 64'hDEADBEEFCAFEF00D);
        run_round(1, 1, 0, 0, 16'h0020, 16'h0040, 64'h0, 64'h0);
        repeat (4) run_round(1, 1, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                             {$urandom, $urandom}, {$urandom, $urandom});
        repeat (40) begin
            sides = $urandom_range(1, 3);
            run_round(sides[0], sides[1], 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                      {$urandom, $urandom}, {$urandom, $urandom});
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Reset during the second ACCESS cycle of a D read.
        @(negedge clk); #1;
        exp_q.push_back('{side: OWN_D, write: 1'b0, addr: 16'h0040, wdata: 64'h0, readyCyc: 32'(cycleCnt + L + 1)});
        d_req = 1; d_write = 0; d_addr = 16'h0040;
        for (int c = 0; c < 20 && !(accActive && strobeCnt == 2); c++) begin
            @(negedge clk); #1;
        end
        if (!(accActive && strobeCnt == 2)) begin
            checks++; errors++;
            $display("FAIL reset_setup actual=strobes %0d required=2", strobeCnt);
        end
        reset_n = 0;
        #1;
        check("arst_readM", readM, 0);
        check("arst_writeM", writeM, 0);
        check("arst_busy", busy, 0);
        check("arst_d_ready", d_ready, 0);
        check("arst_d_rdata", d_rdata, 0);
        d_req = 0;
        exp_q.delete();
        accActive = 0; strobeCnt = 0;
        modelRr = OWN_I; lastI = 0; lastD = 0;
        repeat (2) begin
            @(negedge clk);
            check("arst_no_ready", i_ready | d_ready, 0);
        end
        #1 reset_n = 1;
        run_round(1, 0, 0, 0, 16'h0010, 16'h0000, 64'h0, 64'h0);
        run_round(1, 1, 0, 1, 16'h0033, 16'h0044, 64'h0, {$urandom, $urandom});
        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
